// File: rtl/bit_logic_pipe.sv
// bit_logic_pipe: registered two-operand bitwise unit with configurable latency,
// valid tracking and a saturating count of nonzero results.
// Optional feature macro: BIT_LOGIC_PARITY_EN adds po_parity (XOR-reduce of po_c).
module bit_logic_pipe #(
    parameter int unsigned A_W   = 2,
    parameter int unsigned B_W   = 3,
    parameter int unsigned C_W   = 4,
    parameter int unsigned LAT   = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pi_valid,
    input  logic [1:0]       pi_op,
    input  logic [A_W-1:0]   pi_a,
    input  logic [B_W-1:0]   pi_b,
    input  logic             pi_clr,
    output logic [C_W-1:0]   po_c,
    output logic             po_valid,
    output logic [CNT_W-1:0] po_cnt
`ifdef BIT_LOGIC_PARITY_EN
    ,
    output logic             po_parity
`endif
);

    logic [C_W-1:0] a_x;
    logic [C_W-1:0] b_x;
    logic [C_W-1:0] res;

    // Feed into the output register: either the raw result or the last inner stage.
    logic [C_W-1:0] f_c;
    logic           f_v;

    // Width adaptation (zero-extend or truncate) and operation select.
    always_comb begin
        a_x = C_W'(pi_a);
        b_x = C_W'(pi_b);
        res = '0;
        case (pi_op)
            2'b00:   res = a_x & b_x;
            2'b01:   res = a_x | b_x;
            2'b10:   res = a_x ^ b_x;
            default: res = a_x & ~b_x;  // NOT applies after extension
        endcase
    end

    generate
        if (LAT > 1) begin : g_pipe
            logic [C_W-1:0] s_c [LAT-1];
            logic [LAT-2:0] s_v;

            // Inner delay stages; the output register supplies the final cycle of latency.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s_v <= '0;
                end else begin
                    s_v[0] <= pi_valid;
                    for (int i = LAT - 2; i > 0; i--) begin
                        s_v[i] <= s_v[i-1];
                    end
                end
                s_c[0] <= res;
                for (int i = LAT - 2; i > 0; i--) begin
                    s_c[i] <= s_c[i-1];
                end
            end

            assign f_c = s_c[LAT-2];
            assign f_v = s_v[LAT-2];
        end else begin : g_direct
            assign f_c = res;
            assign f_v = pi_valid;
        end
    endgenerate

    // Output stage: result only moves on a valid, otherwise it holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            po_c     <= '0;
            po_valid <= 1'b0;
        end else begin
            po_valid <= f_v;
            if (f_v) begin
                po_c <= f_c;
            end
        end
    end

`ifdef BIT_LOGIC_PARITY_EN
    // Parity tracks po_c exactly: same enable, same reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            po_parity <= 1'b0;
        end else if (f_v) begin
            po_parity <= ^f_c;
        end
    end
`endif

    // Nonzero-result counter; clear beats increment, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst || pi_clr) begin
            po_cnt <= '0;
        end else if (f_v && (f_c != '0) && (po_cnt != '1)) begin
            po_cnt <= po_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_bit_logic_pipe.sv
// Directed testbench for bit_logic_pipe: default config, LAT=3 config and a
// wide-operand (A_W=6) config, each with hand-computed expectations.
module tb_bit_logic_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Default instance (LAT=1)
    logic       rst0 = 1'b0, v0 = 1'b0, clr0 = 1'b0;
    logic [1:0] op0 = '0, a0 = '0;
    logic [2:0] b0 = '0;
    logic [3:0] c0;
    logic       ov0;
    logic [7:0] cnt0;
`ifdef BIT_LOGIC_PARITY_EN
    logic       par0;
`endif

    bit_logic_pipe u_def (
        .clk      (clk),
        .rst      (rst0),
        .pi_valid (v0),
        .pi_op    (op0),
        .pi_a     (a0),
        .pi_b     (b0),
        .pi_clr   (clr0),
        .po_c     (c0),
        .po_valid (ov0),
        .po_cnt   (cnt0)
`ifdef BIT_LOGIC_PARITY_EN
        ,
        .po_parity(par0)
`endif
    );

    // LAT=3 instance
    logic       rst3 = 1'b0, v3 = 1'b0, clr3 = 1'b0;
    logic [1:0] op3 = '0, a3 = '0;
    logic [2:0] b3 = '0;
    logic [3:0] c3;
    logic       ov3;
    logic [7:0] cnt3;
`ifdef BIT_LOGIC_PARITY_EN
    logic       par3;
`endif

    bit_logic_pipe #(.LAT(3)) u_lat3 (
        .clk      (clk),
        .rst      (rst3),
        .pi_valid (v3),
        .pi_op    (op3),
        .pi_a     (a3),
        .pi_b     (b3),
        .pi_clr   (clr3),
        .po_c     (c3),
        .po_valid (ov3),
        .po_cnt   (cnt3)
`ifdef BIT_LOGIC_PARITY_EN
        ,
        .po_parity(par3)
`endif
    );

    // Wide operand A instance (A_W=6, truncated to C_W=4)
    logic       rstw = 1'b0, vw = 1'b0, clrw = 1'b0;
    logic [1:0] opw = '0;
    logic [5:0] aw = '0;
    logic [2:0] bw = '0;
    logic [3:0] cw;
    logic       ovw;
    logic [7:0] cntw;
`ifdef BIT_LOGIC_PARITY_EN
    logic       parw;
`endif

    bit_logic_pipe #(.A_W(6)) u_wide (
        .clk      (clk),
        .rst      (rstw),
        .pi_valid (vw),
        .pi_op    (opw),
        .pi_a     (aw),
        .pi_b     (bw),
        .pi_clr   (clrw),
        .po_c     (cw),
        .po_valid (ovw),
        .po_cnt   (cntw)
`ifdef BIT_LOGIC_PARITY_EN
        ,
        .po_parity(parw)
`endif
    );

    // LAT=3 stimulus table and hand-computed results
    logic [1:0] t_op  [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    logic [1:0] t_a   [5] = '{2'b11, 2'b01, 2'b11, 2'b10, 2'b01};
    logic [2:0] t_b   [5] = '{3'b110, 3'b100, 3'b111, 3'b000, 3'b011};
    logic [3:0] t_exp [5] = '{4'b0010, 4'b0101, 4'b0100, 4'b0010, 4'b0001};

    initial begin
        // ---------------- default instance ----------------
        rst0 = 1'b1; rst3 = 1'b1; rstw = 1'b1;
        v0 = 1'b1; a0 = 2'b11; b0 = 3'b111;  // reset must override a valid input
        tick();
        check("rst_c",   c0,   4'b0000);
        check("rst_v",   ov0,  1'b0);
        check("rst_cnt", cnt0, 8'd0);
        rst0 = 1'b0; rst3 = 1'b0; rstw = 1'b0;

        v0 = 1'b1; op0 = 2'b00; a0 = 2'b11; b0 = 3'b101;
        tick();
        check("and_c",   c0,   4'b0001);
        check("and_v",   ov0,  1'b1);
        check("and_cnt", cnt0, 8'd1);
        v0 = 1'b0; a0 = 2'b00; op0 = 2'b01;
        tick();
        check("idle_v",  ov0, 1'b0);
        check("idle_c",  c0,  4'b0001);

        v0 = 1'b1; a0 = 2'b10; b0 = 3'b011;
        op0 = 2'b01; tick(); check("or_c",  c0, 4'b0011); check("or_cnt", cnt0, 8'd2);
        op0 = 2'b10; tick(); check("xor_c", c0, 4'b0001); check("xor_cnt", cnt0, 8'd3);
        op0 = 2'b11; tick(); check("andn_c", c0, 4'b0000); check("zero_cnt", cnt0, 8'd3);
        a0 = 2'b11; b0 = 3'b001;
        tick();
        check("andn2_c", c0, 4'b0010);
        check("andn2_v", ov0, 1'b1);
`ifdef BIT_LOGIC_PARITY_EN
        check("par0", par0, 1'b1);
`endif
        v0 = 1'b0; a0 = 2'b01; op0 = 2'b01;
        tick();
        check("hold_c", c0, 4'b0010);

        // counter: clear, zeros do not count, saturation
        clr0 = 1'b1; tick(); clr0 = 1'b0;
        check("clr_cnt", cnt0, 8'd0);
        check("clr_keep_c", c0, 4'b0010);
        v0 = 1'b1; op0 = 2'b00; a0 = 2'b00; b0 = 3'b111;
        for (int i = 0; i < 3; i++) tick();
        check("zeros_cnt", cnt0, 8'd0);
        a0 = 2'b11;
        for (int i = 0; i < 100; i++) tick();
        check("cnt100", cnt0, 8'd100);
        a0 = 2'b00; tick();
        check("zero_mid_cnt", cnt0, 8'd100);
        a0 = 2'b11;
        for (int i = 0; i < 200; i++) tick();
        check("sat_cnt", cnt0, 8'd255);
        a0 = 2'b00; tick();
        check("sat_zero_cnt", cnt0, 8'd255);

        // clear priority over a landing nonzero result
        v0 = 1'b0; clr0 = 1'b1; tick(); clr0 = 1'b0;
        v0 = 1'b1; a0 = 2'b11;
        for (int i = 0; i < 10; i++) tick();
        check("cnt10", cnt0, 8'd10);
        clr0 = 1'b1; op0 = 2'b01; a0 = 2'b01; b0 = 3'b000;
        tick();
        clr0 = 1'b0;
        check("clrpri_cnt", cnt0, 8'd0);
        check("clrpri_c",   c0,   4'b0001);
        check("clrpri_v",   ov0,  1'b1);
        a0 = 2'b10;
        tick();
        check("after_clr_cnt", cnt0, 8'd1);
        check("after_clr_c",   c0,   4'b0010);
        v0 = 1'b0;

        // ---------------- LAT=3 back-to-back ----------------
        for (int k = 0; k < 7; k++) begin
            v3 = (k < 5);
            if (k < 5) begin
                op3 = t_op[k]; a3 = t_a[k]; b3 = t_b[k];
            end else begin
                op3 = 2'b11; a3 = 2'b00; b3 = 3'b111;  // op change must not disturb in-flight
            end
            tick();
            if (k >= 2) begin
                check($sformatf("l3_v%0d", k), ov3, 1'b1);
                check($sformatf("l3_c%0d", k), c3, t_exp[k-2]);
            end else begin
                check($sformatf("l3_v%0d", k), ov3, 1'b0);
            end
        end
        v3 = 1'b0;
        tick();
        check("l3_drain_v", ov3, 1'b0);
        check("l3_cnt", cnt3, 8'd5);

        // reset during the third input discards everything in flight
        for (int k = 0; k < 3; k++) begin
            v3 = 1'b1; op3 = t_op[k]; a3 = t_a[k]; b3 = t_b[k];
            rst3 = (k == 2);
            tick();
            check($sformatf("l3r_v%0d", k), ov3, 1'b0);
        end
        rst3 = 1'b0; v3 = 1'b0;
        check("l3r_c",   c3,   4'b0000);
        check("l3r_cnt", cnt3, 8'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("l3r_post_v%0d", k), ov3, 1'b0);
        end

        // ---------------- wide operand truncation ----------------
        vw = 1'b1; opw = 2'b01; aw = 6'b110101; bw = 3'b111;
        tick();
        check("wide_or_c", cw, 4'b0111);
        check("wide_or_v", ovw, 1'b1);
`ifdef BIT_LOGIC_PARITY_EN
        check("wide_par", parw, 1'b1);
`endif
        opw = 2'b11; aw = 6'b101010; bw = 3'b001;
        tick();
        check("wide_andn_c", cw, 4'b1010);
        check("wide_cnt", cntw, 8'd2);
        vw = 1'b0;
        tick();
        check("wide_hold_c", cw, 4'b1010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
